// File: rtl/fix_mult_share_ctrl_pkg.sv
// Shared types, default geometry and the fixed product rescale rule
// for the time-shared fixed-point multiplier.
package fix_mult_pkg;

  localparam int N_REQ_D     = 4;
  localparam int FIX_BW_0_D  = 9;
  localparam int PNT_POS_0_D = 7;
  localparam int FIX_BW_1_D  = 9;
  localparam int PNT_POS_1_D = 7;
  localparam int MUL_LAT_D   = 2;

  localparam int MDPNT  = 2*PNT_POS_0_D - 1;
  localparam int INT_BW = FIX_BW_1_D - PNT_POS_1_D;

  // Stage entry layout for the default geometry.
  typedef struct packed {
    logic                          valid;
    logic [$clog2(N_REQ_D)-1:0]    id;
    logic [2*FIX_BW_0_D-1:0]       acc;
  } stage_t;

  // {acc[mdpnt+1 +: int_bw], acc[mdpnt -: pnt_pos_1]} is one contiguous field
  // starting at mdpnt+1-pnt_pos_1; truncate fraction, wrap integer part.
  function automatic logic [31:0] fix_rescale(input logic [63:0] acc,
                                              input int mdpnt,
                                              input int pnt_pos_1,
                                              input int fix_bw_1);
    logic [31:0] mask;
    mask = (fix_bw_1 >= 32) ? '1 : 32'((64'd1 << fix_bw_1) - 64'd1);
    return 32'(acc >> (mdpnt + 1 - pnt_pos_1)) & mask;
  endfunction

endpackage

// File: rtl/fix_mult_share_ctrl_if.sv
// Requester and response bus of the shared multiplier; slave is the controller.
interface fix_mult_share_ctrl_if #(
  parameter int N_REQ    = 4,
  parameter int FIX_BW_0 = 9,
  parameter int FIX_BW_1 = 9
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*FIX_BW_0-1:0] req_a;
  logic [N_REQ*FIX_BW_0-1:0] req_b;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [FIX_BW_1-1:0]       resp_data;
  logic                      idle;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, idle
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, idle
  );
endinterface

// File: rtl/fix_mult_share_ctrl_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// pointer moves past the winner only when a grant is issued.
module fix_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [N-1:0]  rot;
  logic [PW:0]   sum;
  logic          found;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    // Rotate so bit 0 is the current pointer; first hit wins.
    rot   = N'({req, req} >> ptr);
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (PW+1)'(k);
        gidx  = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      end
    end
    grant = (advance && found) ? (N'(1) << gidx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= '0;
    else if (|grant) ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/fix_mult_share_ctrl.sv
// Time-shares one pipelined unsigned fixed-point multiplier among N_REQ
// requesters; tagged results leave in acceptance order under a global stall.
module fix_mult_share_ctrl
  import fix_mult_pkg::*;
#(
  parameter int N_REQ     = N_REQ_D,
  parameter int FIX_BW_0  = FIX_BW_0_D,
  parameter int PNT_POS_0 = PNT_POS_0_D,
  parameter int FIX_BW_1  = FIX_BW_1_D,
  parameter int PNT_POS_1 = PNT_POS_1_D,
  parameter int MUL_LAT   = MUL_LAT_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fix_mult_share_ctrl_if.slave bus
);
  localparam int ID_W    = $clog2(N_REQ);
  localparam int ACC_W   = 2*FIX_BW_0;
  localparam int MDPNT_L = 2*PNT_POS_0 - 1;

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [ACC_W-1:0] acc;
  } ent_t;

  logic                stall;
  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     gid;
  logic [FIX_BW_0-1:0] a_sel, b_sel;
  logic [ACC_W-1:0]    acc_in;
  logic [MUL_LAT-1:0]  vld_pipe;
  ent_t                stg [MUL_LAT];

  assign stall = stg[MUL_LAT-1].valid & ~bus.resp_ready;

  fix_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (~stall),
    .grant   (grant)
  );

  assign bus.req_ready = grant;

  // One-hot grant steers the operand pair and its tag.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    gid   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = bus.req_a[i*FIX_BW_0 +: FIX_BW_0];
        b_sel = bus.req_b[i*FIX_BW_0 +: FIX_BW_0];
        gid   = ID_W'(i);
      end
    end
  end

  assign acc_in = ACC_W'(a_sel) * ACC_W'(b_sel);

  // Whole pipe freezes when the head result is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= '{valid: |grant, id: gid, acc: acc_in};
      for (int i = 1; i < MUL_LAT; i++) stg[i] <= stg[i-1];
    end
  end

  for (genvar s = 0; s < MUL_LAT; s++) begin : g_vld
    assign vld_pipe[s] = stg[s].valid;
  end

  assign bus.idle       = ~|vld_pipe;
  assign bus.resp_valid = stg[MUL_LAT-1].valid;
  assign bus.resp_id    = stg[MUL_LAT-1].id;
  assign bus.resp_data  = FIX_BW_1'(fix_rescale(64'(stg[MUL_LAT-1].acc),
                                                MDPNT_L, PNT_POS_1, FIX_BW_1));

endmodule

// File: tb/tb_fix_mult_share_ctrl.sv
// Directed bench for fix_mult_share_ctrl at default geometry (Q2.7 in/out, 2-stage).
module tb_fix_mult_share_ctrl;
  localparam int N   = 4;
  localparam int BW0 = 9;
  localparam int BW1 = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   nvec  = 0;
  int   nerr  = 0;

  // Hand-computed products >> 7 for the per-requester operand table below.
  logic [31:0] exp_d [4] = '{32'd32, 32'd128, 32'd288, 32'd64};

  fix_mult_share_ctrl_if #(.N_REQ(N), .FIX_BW_0(BW0), .FIX_BW_1(BW1)) bus ();

  fix_mult_share_ctrl #(
    .N_REQ(N), .FIX_BW_0(BW0), .PNT_POS_0(7),
    .FIX_BW_1(BW1), .PNT_POS_1(7), .MUL_LAT(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input int id, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.resp_id),    32'(id));
    chk({tag, "_data"},  32'(bus.resp_data),  d);
  endtask

  task automatic set_ops(input int i, input logic [BW0-1:0] a, input logic [BW0-1:0] b);
    bus.req_a[i*BW0 +: BW0] = a;
    bus.req_b[i*BW0 +: BW0] = b;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_idle",       32'(bus.idle),       32'd1);
    chk("rst_resp_id",    32'(bus.resp_id),    32'd0);
    chk("rst_resp_data",  32'(bus.resp_data),  32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
    tick();
    rst_n = 1'b1;
    set_ops(0, 9'd64, 9'd64);
    set_ops(1, 9'd128, 9'd128);
    set_ops(2, 9'd192, 9'd192);
    set_ops(3, 9'd128, 9'd64);
    tick();

    // Single request: 0.5*0.5 = 0.25, visible one edge after acceptance
    bus.req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    #1;
    chk("t1_early_valid", 32'(bus.resp_valid), 32'd0);
    chk("t1_busy",        32'(bus.idle),       32'd0);
    tick();
    chk_resp("t1", 0, 32'd32);
    tick();
    chk("t1_drain_valid", 32'(bus.resp_valid), 32'd0);
    chk("t1_drain_idle",  32'(bus.idle),       32'd1);

    // 1.5^2 = 2.25, then 511^2 wraps to 504; pointer wraps back to req0
    set_ops(0, 9'd192, 9'd192);
    bus.req_valid = 4'b0001;
    tick();
    set_ops(0, 9'd511, 9'd511);
    #1 chk("t2_wrap_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    #1 chk_resp("t2_150", 0, 32'd288);
    tick();
    chk_resp("t2_511", 0, 32'd504);
    tick();
    chk("t2_drain_valid", 32'(bus.resp_valid), 32'd0);
    set_ops(0, 9'd64, 9'd64);

    // Grant req1 alone so the pointer sits at 2
    bus.req_valid = 4'b0010;
    #1 chk("t5_pre_ready", 32'(bus.req_ready), 32'd2);
    tick();
    bus.req_valid = '0;
    tick();
    chk_resp("t5_pre", 1, 32'd128);
    tick();

    // req1+req3 with pointer 2: req3 first, then req1
    bus.req_valid = 4'b1010;
    #1 chk("t5_first", 32'(bus.req_ready), 32'd8);
    tick();
    chk("t5_second", 32'(bus.req_ready), 32'd2);
    tick();
    bus.req_valid = '0;
    #1 chk_resp("t5_r3", 3, 32'd64);
    tick();
    chk_resp("t5_r1", 1, 32'd128);
    tick();
    chk("t5_drain_valid", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 4'b1111;
    #1 chk("t5_ptr_end", 32'(bus.req_ready), 32'd4);

    // Park the pointer at 0 by granting req3
    bus.req_valid = 4'b1000;
    #1 chk("t3_pre_ready", 32'(bus.req_ready), 32'd8);
    tick();
    bus.req_valid = 4'b1111;
    #1;
    chk("t3_start_ready", 32'(bus.req_ready), 32'd1);
    chk("t3_start_valid", 32'(bus.resp_valid), 32'd0);

    // All valid: grants 0,1,2,3,... and one result per cycle in the same order
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("t3_ready", 32'(bus.req_ready), 32'(1 << (j % 4)));
      chk_resp("t3", (j + 2) % 4, exp_d[(j + 2) % 4]);
    end

    // Backpressure with a full pipe: everything frozen for 5 cycles
    bus.resp_ready = 1'b0;
    #1;
    for (int h = 0; h < 5; h++) begin
      chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_hold_idle",  32'(bus.idle),      32'd0);
      chk_resp("t4_hold", 2, 32'd288);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1 chk("t4_rel_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk_resp("t4_next", 3, 32'd64);
    tick();
    chk_resp("t4_new0", 0, 32'd32);
    bus.req_valid = '0;
    tick();
    chk_resp("t4_new1", 1, 32'd128);
    tick();
    chk("t4_drain_valid", 32'(bus.resp_valid), 32'd0);
    chk("t4_drain_idle",  32'(bus.idle),       32'd1);

    // Reset with two entries in flight
    bus.req_valid = 4'b1111;
    tick();
    tick();
    bus.req_valid = '0;
    #1 chk_resp("t6_inflight", 2, 32'd288);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("t6_rst_idle",  32'(bus.idle),       32'd1);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1 chk("t6_first_grant", 32'(bus.req_ready), 32'd1);
    tick();
    chk("t6_no_replay", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = '0;
    tick();
    chk_resp("t6_after", 0, 32'd32);
    tick();
    chk("t6_end_idle", 32'(bus.idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
